// File: rtl/mdc_delay_switch.sv
// Delay-switch-delay reorder stage for the MDC FFT pipeline.
// Pairs samples DEPTH apart onto the same output cycle.
module mdc_delay_switch #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    frame_start,
  input  logic signed [WIDTH-1:0] inU_re,
  input  logic signed [WIDTH-1:0] inU_im,
  input  logic signed [WIDTH-1:0] inL_re,
  input  logic signed [WIDTH-1:0] inL_im,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] outU_re,
  output logic signed [WIDTH-1:0] outU_im,
  output logic signed [WIDTH-1:0] outL_re,
  output logic signed [WIDTH-1:0] outL_im
);

  localparam int CW = $clog2(2 * DEPTH);
  localparam int SB = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [CW-1:0] cnt;
  logic [CW-1:0] n;
  logic [FW-1:0] fill;
  logic          primed;
  logic          sel;

  logic signed [WIDTH-1:0] du_re [DEPTH];
  logic signed [WIDTH-1:0] du_im [DEPTH];
  logic signed [WIDTH-1:0] dl_re [DEPTH];
  logic signed [WIDTH-1:0] dl_im [DEPTH];

  logic signed [WIDTH-1:0] top_re, top_im;
  logic signed [WIDTH-1:0] bot_re, bot_im;

  always_comb begin
    n      = frame_start ? '0 : cnt;
    sel    = n[SB];
    primed = (fill == FULL);
    top_re = du_re[DEPTH-1];
    top_im = du_im[DEPTH-1];
    bot_re = inL_re;
    bot_im = inL_im;
    if (sel) begin
      top_re = inL_re;
      top_im = inL_im;
      bot_re = du_re[DEPTH-1];
      bot_im = du_im[DEPTH-1];
    end
  end

  // primed reflects fill before this sample, so the
  // frame_start sample itself may still emit a valid pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      fill <= '0;
    end else if (in_valid) begin
      cnt <= n + CW'(1);
      if (frame_start)
        fill <= FW'(1);
      else if (!primed)
        fill <= fill + FW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        du_re[i] <= '0;
        du_im[i] <= '0;
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else if (in_valid) begin
      du_re[0] <= inU_re;
      du_im[0] <= inU_im;
      dl_re[0] <= bot_re;
      dl_im[0] <= bot_im;
      for (int i = 1; i < DEPTH; i++) begin
        du_re[i] <= du_re[i-1];
        du_im[i] <= du_im[i-1];
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      outU_re   <= '0;
      outU_im   <= '0;
      outL_re   <= '0;
      outL_im   <= '0;
    end else begin
      out_valid <= in_valid && primed;
      if (in_valid) begin
        outU_re <= top_re;
        outU_im <= top_im;
        outL_re <= dl_re[DEPTH-1];
        outL_im <= dl_im[DEPTH-1];
      end
    end
  end

endmodule
